// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the single CPU-side cache port.
// One transaction in flight; the response is routed to its owner only.
module cache_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          cache_req_valid,
    input  logic                          cache_req_ready,
    output logic                          cache_req_rw,
    output logic [ADDR_WIDTH-1:0]         cache_req_addr,
    output logic [DATA_WIDTH-1:0]         cache_req_wdata,
    input  logic                          cache_rsp_valid,
    input  logic [DATA_WIDTH-1:0]         cache_rsp_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [PTR_W-1:0]      rr_ptr_q;
    logic [PTR_W-1:0]      owner_q;
    logic [PTR_W-1:0]      grant;
    logic                  grant_found;
    logic                  accept;
    logic                  capture;
    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found &&
                req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        capture         = 1'b0;
        accept          = 1'b0;
        req_ready       = '0;
        rsp_valid       = '0;
        cache_req_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cache_req_valid = 1'b1;
                if (cache_req_ready) begin
                    if (cache_rsp_valid) begin
                        capture = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cache_rsp_valid) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= grant;
                rw_q    <= req_rw[grant];
                addr_q  <= req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (capture) begin
                rdata_q <= cache_rsp_rdata;
            end
            if (state_q == S_RESP) begin
                rr_ptr_q <= (owner_q == PTR_W'(NUM_REQ - 1)) ?
                            '0 : owner_q + 1'b1;
            end
        end
    end

    assign cache_req_rw    = rw_q;
    assign cache_req_addr  = addr_q;
    assign cache_req_wdata = wdata_q;
    assign rsp_rdata       = rdata_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with two requesters.
// Each task drives one scenario and checks outputs one ns after inputs settle.
module tb_cache_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_rw = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            cache_req_valid;
    logic            cache_req_ready = 1'b0;
    logic            cache_req_rw;
    logic [AW-1:0]   cache_req_addr;
    logic [DW-1:0]   cache_req_wdata;
    logic            cache_rsp_valid = 1'b0;
    logic [DW-1:0]   cache_rsp_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .cache_req_valid(cache_req_valid),
        .cache_req_ready(cache_req_ready),
        .cache_req_rw(cache_req_rw),
        .cache_req_addr(cache_req_addr),
        .cache_req_wdata(cache_req_wdata),
        .cache_rsp_valid(cache_rsp_valid),
        .cache_rsp_rdata(cache_rsp_rdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        repeat (2) step();
        checks++;
        if (cache_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_cvalid got %b want 0", cache_req_valid);
        end
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rst_rspv got %b want 00", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata got %h want 0", rsp_rdata);
        end
        checks++;
        if (cache_req_rw !== 1'b0) begin
            errors++;
            $display("FAIL rst_rw got %b want 0", cache_req_rw);
        end
        checks++;
        if (cache_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_addr got %h want 0", cache_req_addr);
        end
        checks++;
        if (cache_req_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_wdata got %h want 0", cache_req_wdata);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_wait;
        req_valid = 2'b01;
        req_addr[0 +: AW] = 32'h100;
        settle();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmw_rdy1 got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        cache_req_ready = 1'b1;
        cache_rsp_valid = 1'b1;
        cache_rsp_rdata = 32'h1111_1111;
        settle();
        step();
        cache_req_ready = 1'b0;
        cache_rsp_valid = 1'b0;
        settle();
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL rmw_rsp1 got %b want 01", rsp_valid);
        end
        step();
        // rr_ptr is now 1; start a req0 transaction and stall in WAIT
        req_valid = 2'b01;
        req_addr[0 +: AW] = 32'h200;
        settle();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmw_rdy2 got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        cache_req_ready = 1'b1;
        settle();
        step();
        cache_req_ready = 1'b0;
        settle();
        checks++;
        if (cache_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmw_wait got %b want 0", cache_req_valid);
        end
        step();
        rst = 1'b0;
        settle();
        checks++;
        if (cache_req_valid !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rmw_inrst got %b/%b want 0/00",
                     cache_req_valid, rsp_valid);
        end
        step();
        rst = 1'b1;
        cache_rsp_valid = 1'b1;
        cache_rsp_rdata = 32'h2222_2222;
        settle();
        step();
        cache_rsp_valid = 1'b0;
        settle();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmw_norsp got %b/%h want 00/0",
                     rsp_valid, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rmw_norsp2 got %b want 00", rsp_valid);
        end
        req_valid = 2'b11;
        settle();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmw_grant got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        settle();
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp;
        logic [AW-1:0] ea;
        req_addr[0 +: AW] = 32'h1000;
        req_addr[AW +: AW] = 32'h2000;
        req_valid = 2'b11;
        cache_req_ready = 1'b1;
        cache_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            ea = (i % 2 == 0) ? 32'h1000 : 32'h2000;
            settle();
            checks++;
            if (req_ready !== exp) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b",
                         i, req_ready, exp);
            end
            step();
            cache_rsp_rdata = 32'hA0 + i;
            settle();
            checks++;
            if (cache_req_valid !== 1'b1 || cache_req_addr !== ea) begin
                errors++;
                $display("FAIL rr_issue%0d got %b/%h want 1/%h",
                         i, cache_req_valid, cache_req_addr, ea);
            end
            step();
            checks++;
            if (rsp_valid !== exp || rsp_rdata !== 32'hA0 + i) begin
                errors++;
                $display("FAIL rr_rsp%0d got %b/%h want %b/%h",
                         i, rsp_valid, rsp_rdata, exp, 32'hA0 + i);
            end
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL rr_rdy_resp%0d got %b want 00",
                         i, req_ready);
            end
            step();
        end
        req_valid = 2'b00;
        cache_req_ready = 1'b0;
        cache_rsp_valid = 1'b0;
        settle();
    endtask

    task automatic test_stall;
        req_valid = 2'b10;
        req_rw[1] = 1'b0;
        req_addr[AW +: AW] = 32'h40;
        settle();
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL st_grant got %b want 10", req_ready);
        end
        step();
        req_valid = 2'b00;
        req_addr[AW +: AW] = 32'hFFFF;
        req_rw[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cache_rsp_valid = (i == 1);
            cache_rsp_rdata = 32'hBAD0_0BAD;
            settle();
            checks++;
            if (cache_req_valid !== 1'b1 || cache_req_addr !== 32'h40 ||
                cache_req_rw !== 1'b0) begin
                errors++;
                $display("FAIL st_hold%0d got %b/%h/%b want 1/40/0",
                         i, cache_req_valid, cache_req_addr, cache_req_rw);
            end
            step();
        end
        cache_rsp_valid = 1'b0;
        cache_req_ready = 1'b1;
        settle();
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL st_early got %b want 00", rsp_valid);
        end
        step();
        cache_req_ready = 1'b0;
        cache_rsp_valid = 1'b1;
        cache_rsp_rdata = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (cache_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL st_wait got %b want 0", cache_req_valid);
        end
        step();
        cache_rsp_valid = 1'b0;
        settle();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL st_rsp got %b/%h want 10/deadbeef",
                     rsp_valid, rsp_rdata);
        end
        step();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL st_after got %b/%h want 00/deadbeef",
                     rsp_valid, rsp_rdata);
        end
        req_rw[1] = 1'b0;
    endtask

    task automatic test_hit_write;
        req_valid = 2'b01;
        req_rw[0] = 1'b1;
        req_addr[0 +: AW] = 32'h80;
        req_wdata[0 +: DW] = 32'h1234_5678;
        settle();
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL hw_grant got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        cache_req_ready = 1'b1;
        cache_rsp_valid = 1'b1;
        cache_rsp_rdata = 32'h55;
        settle();
        checks++;
        if (cache_req_rw !== 1'b1 || cache_req_wdata !== 32'h1234_5678 ||
            cache_req_addr !== 32'h80) begin
            errors++;
            $display("FAIL hw_fields got %b/%h/%h want 1/12345678/80",
                     cache_req_rw, cache_req_wdata, cache_req_addr);
        end
        step();
        cache_req_ready = 1'b0;
        cache_rsp_valid = 1'b0;
        settle();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h55) begin
            errors++;
            $display("FAIL hw_rsp got %b/%h want 01/55",
                     rsp_valid, rsp_rdata);
        end
        step();
        req_rw[0] = 1'b0;
    endtask

    task automatic test_single_requester;
        req_valid = 2'b01;
        cache_req_ready = 1'b1;
        cache_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (req_ready !== 2'b01) begin
                errors++;
                $display("FAIL sr_grant%0d got %b want 01", i, req_ready);
            end
            step();
            checks++;
            if (req_ready[1] !== 1'b0 || cache_req_valid !== 1'b1) begin
                errors++;
                $display("FAIL sr_issue%0d got %b/%b want 0/1",
                         i, req_ready[1], cache_req_valid);
            end
            step();
            checks++;
            if (rsp_valid !== 2'b01 || req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL sr_rsp%0d got %b/%b want 01/0",
                         i, rsp_valid, req_ready[1]);
            end
            step();
        end
        req_valid = 2'b00;
        cache_req_ready = 1'b0;
        cache_rsp_valid = 1'b0;
        cache_rsp_rdata = 32'h55;
        settle();
    endtask

    task automatic test_spurious;
        cache_rsp_valid = 1'b1;
        cache_rsp_rdata = 32'h999;
        settle();
        step();
        checks++;
        if (rsp_valid !== 2'b00 || cache_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL sp_rsp got %b/%b want 00/0",
                     rsp_valid, cache_req_valid);
        end
        step();
        cache_rsp_valid = 1'b0;
        settle();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h55) begin
            errors++;
            $display("FAIL sp_hold got %b/%h want 00/55",
                     rsp_valid, rsp_rdata);
        end
        // rr_ptr is 1 after the req0-only run, and the FSM must still be idle
        req_valid = 2'b11;
        settle();
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL sp_idle got %b want 10", req_ready);
        end
        req_valid = 2'b00;
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_round_robin();
        test_stall();
        test_hit_write();
        test_single_requester();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
